// File: rtl/itlb_sv39.sv
// Fully-associative Sv39 instruction TLB in front of the page walker.
// Optional hit/miss counters are built when ITLB_PERF_CNT_EN is defined.
module itlb_sv39 #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lookup_valid,
    input  logic [63:0] lookup_vaddr,
    output logic        lookup_ready,
    input  logic [1:0]  mode,
    input  logic [63:0] satp,
    input  logic        flush,
    output logic        resp_valid,
    output logic [63:0] resp_paddr,
    output logic        resp_fault,
    output logic        walk_req_valid,
    output logic [26:0] walk_req_vpn,
    input  logic        walk_req_ready,
    input  logic        walk_resp_valid,
    input  logic [43:0] walk_resp_ppn,
`ifdef ITLB_PERF_CNT_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    input  logic        walk_resp_fault
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned VPN_W = 27;
    localparam int unsigned PPN_W = 44;
    localparam int unsigned OFF_W = 12;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WALK_REQ  = 2'd1,
        WALK_WAIT = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [PPN_W-1:0]   ppn_q [ENTRIES];
    logic [IDX_W-1:0]   ptr_q;
    logic [OFF_W-1:0]   off_q, off_d;
    logic               kill_q, kill_d;
    logic               resp_valid_q, resp_valid_d;
    logic [63:0]        resp_paddr_q, resp_paddr_d;
    logic               resp_fault_q, resp_fault_d;
    logic               walk_req_valid_q, walk_req_valid_d;
    logic [VPN_W-1:0]   walk_req_vpn_q, walk_req_vpn_d;

    logic               bypass_c;
    logic               hit_c;
    logic               hit_any_c;
    logic [IDX_W-1:0]   hit_idx_c;
    logic               free_c;
    logic [IDX_W-1:0]   free_idx_c;
    logic [IDX_W-1:0]   victim_idx_c;
    logic               fill_en_c;
    logic               count_hit_c;
    logic               count_miss_c;
    logic               satp_unused_c;

    assign satp_unused_c = ^satp[59:0];
    assign bypass_c      = (mode == 2'd3) || (satp[63:60] != 4'd8);

    // Parallel VPN compare; descending scan leaves the lowest matching index
    always_comb begin
        hit_any_c = 1'b0;
        hit_idx_c = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == lookup_vaddr[38:12])) begin
                hit_any_c = 1'b1;
                hit_idx_c = IDX_W'(i);
            end
        end
    end

    // A same-cycle flush makes the compare see an empty TLB
    assign hit_c = hit_any_c && !flush;

    // Victim: lowest invalid entry, otherwise the round-robin pointer
    always_comb begin
        free_c     = 1'b0;
        free_idx_c = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_c     = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    assign victim_idx_c = free_c ? free_idx_c : ptr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        off_d            = off_q;
        kill_d           = kill_q;
        resp_valid_d     = 1'b0;
        resp_paddr_d     = '0;
        resp_fault_d     = 1'b0;
        walk_req_valid_d = walk_req_valid_q;
        walk_req_vpn_d   = walk_req_vpn_q;
        fill_en_c        = 1'b0;
        count_hit_c      = 1'b0;
        count_miss_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_valid) begin
                    off_d = lookup_vaddr[OFF_W-1:0];
                    if (bypass_c) begin
                        resp_valid_d = 1'b1;
                        resp_paddr_d = lookup_vaddr;
                    end else if (hit_c) begin
                        count_hit_c  = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_paddr_d = {8'b0, ppn_q[hit_idx_c], lookup_vaddr[OFF_W-1:0]};
                    end else begin
                        count_miss_c     = 1'b1;
                        kill_d           = 1'b0;
                        walk_req_valid_d = 1'b1;
                        walk_req_vpn_d   = lookup_vaddr[38:12];
                        state_d          = WALK_REQ;
                    end
                end
            end
            WALK_REQ: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (walk_req_ready) begin
                    walk_req_valid_d = 1'b0;
                    state_d          = WALK_WAIT;
                end
            end
            WALK_WAIT: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (walk_resp_valid) begin
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                    if (walk_resp_fault) begin
                        resp_fault_d = 1'b1;
                    end else begin
                        resp_paddr_d = {8'b0, walk_resp_ppn, off_q};
                        fill_en_c    = !kill_q && !flush;
                    end
                end
            end
            default: begin
                state_d          = IDLE;
                walk_req_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            off_q            <= '0;
            kill_q           <= 1'b0;
            resp_valid_q     <= 1'b0;
            resp_paddr_q     <= '0;
            resp_fault_q     <= 1'b0;
            walk_req_valid_q <= 1'b0;
            walk_req_vpn_q   <= '0;
        end else begin
            off_q            <= off_d;
            kill_q           <= kill_d;
            resp_valid_q     <= resp_valid_d;
            resp_paddr_q     <= resp_paddr_d;
            resp_fault_q     <= resp_fault_d;
            walk_req_valid_q <= walk_req_valid_d;
            walk_req_vpn_q   <= walk_req_vpn_d;
        end
    end

    // Entry array; flush takes priority over a same-cycle fill
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                vpn_q[i] <= '0;
                ppn_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (fill_en_c) begin
            valid_q[victim_idx_c] <= 1'b1;
            vpn_q[victim_idx_c]   <= walk_req_vpn_q;
            ppn_q[victim_idx_c]   <= walk_resp_ppn;
            if (!free_c) begin
                ptr_q <= IDX_W'(ptr_q + 1'b1);
            end
        end
    end

`ifdef ITLB_PERF_CNT_EN
    logic [31:0] hit_count_q, miss_count_q;

    // Saturating counters, untouched by flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (count_hit_c && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (count_miss_c && (miss_count_q != 32'hFFFF_FFFF)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

    assign lookup_ready   = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_paddr     = resp_paddr_q;
    assign resp_fault     = resp_fault_q;
    assign walk_req_valid = walk_req_valid_q;
    assign walk_req_vpn   = walk_req_vpn_q;

endmodule

// File: tb/tb_itlb_sv39.sv
// Directed self-checking bench for itlb_sv39 (ENTRIES = 8).
module tb_itlb_sv39;

    localparam logic [63:0] SATP_SV39 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [63:0] lookup_vaddr;
    logic        lookup_ready;
    logic [1:0]  mode;
    logic [63:0] satp;
    logic        flush;
    logic        resp_valid;
    logic [63:0] resp_paddr;
    logic        resp_fault;
    logic        walk_req_valid;
    logic [26:0] walk_req_vpn;
    logic        walk_req_ready;
    logic        walk_resp_valid;
    logic [43:0] walk_resp_ppn;
    logic        walk_resp_fault;
`ifdef ITLB_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    itlb_sv39 #(.ENTRIES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_vaddr   (lookup_vaddr),
        .lookup_ready   (lookup_ready),
        .mode           (mode),
        .satp           (satp),
        .flush          (flush),
        .resp_valid     (resp_valid),
        .resp_paddr     (resp_paddr),
        .resp_fault     (resp_fault),
        .walk_req_valid (walk_req_valid),
        .walk_req_vpn   (walk_req_vpn),
        .walk_req_ready (walk_req_ready),
        .walk_resp_valid(walk_resp_valid),
        .walk_resp_ppn  (walk_resp_ppn),
`ifdef ITLB_PERF_CNT_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .walk_resp_fault(walk_resp_fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Lookup expected to answer locally (bypass or hit) one cycle later
    task automatic local_lookup(input string tag, input logic [63:0] va, input logic [63:0] exp_pa);
        lookup_valid = 1'b1;
        lookup_vaddr = va;
        step();
        lookup_valid = 1'b0;
        check({tag, "_rv"},   64'(resp_valid), 64'd1);
        check({tag, "_pa"},   resp_paddr, exp_pa);
        check({tag, "_flt"},  64'(resp_fault), 64'd0);
        check({tag, "_nowk"}, 64'(walk_req_valid), 64'd0);
    endtask

    // Lookup expected to miss and raise a walk request
    task automatic start_miss(input string tag, input logic [63:0] va, input logic [26:0] exp_vpn);
        lookup_valid = 1'b1;
        lookup_vaddr = va;
        step();
        lookup_valid = 1'b0;
        check({tag, "_wreq"}, 64'(walk_req_valid), 64'd1);
        check({tag, "_vpn"},  64'(walk_req_vpn), 64'(exp_vpn));
        check({tag, "_norv"}, 64'(resp_valid), 64'd0);
        check({tag, "_nrdy"}, 64'(lookup_ready), 64'd0);
    endtask

    task automatic finish_walk(input string tag, input logic [26:0] exp_vpn, input bit flush_mid,
                               input logic [43:0] ppn, input bit fault, input logic [63:0] exp_pa);
        step();
        check({tag, "_hold"},  64'(walk_req_valid), 64'd1);
        check({tag, "_holdv"}, 64'(walk_req_vpn), 64'(exp_vpn));
        walk_req_ready = 1'b1;
        step();
        walk_req_ready = 1'b0;
        check({tag, "_wdrop"}, 64'(walk_req_valid), 64'd0);
        if (flush_mid) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
        end
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = ppn;
        walk_resp_fault = fault;
        step();
        walk_resp_valid = 1'b0;
        walk_resp_fault = 1'b0;
        check({tag, "_rv"},  64'(resp_valid), 64'd1);
        check({tag, "_flt"}, 64'(resp_fault), 64'(fault));
        check({tag, "_pa"},  resp_paddr, exp_pa);
        check({tag, "_rdy"}, 64'(lookup_ready), 64'd1);
    endtask

    task automatic walk_txn(input string tag, input logic [63:0] va, input logic [26:0] exp_vpn,
                            input bit flush_mid, input logic [43:0] ppn, input bit fault,
                            input logic [63:0] exp_pa);
        start_miss(tag, va, exp_vpn);
        finish_walk(tag, exp_vpn, flush_mid, ppn, fault, exp_pa);
    endtask

    initial begin
        reset           = 1'b1;
        lookup_valid    = 1'b0;
        lookup_vaddr    = '0;
        mode            = 2'd0;
        satp            = '0;
        flush           = 1'b0;
        walk_req_ready  = 1'b0;
        walk_resp_valid = 1'b0;
        walk_resp_ppn   = '0;
        walk_resp_fault = 1'b0;
        step();
        step();
        check("rst_rv",    64'(resp_valid), 64'd0);
        check("rst_pa",    resp_paddr, 64'd0);
        check("rst_flt",   64'(resp_fault), 64'd0);
        check("rst_wreq",  64'(walk_req_valid), 64'd0);
        check("rst_wvpn",  64'(walk_req_vpn), 64'd0);
        check("rst_ready", 64'(lookup_ready), 64'd1);
`ifdef ITLB_PERF_CNT_EN
        check("rst_hitc",  64'(hit_count), 64'd0);
        check("rst_missc", 64'(miss_count), 64'd0);
`endif
        reset = 1'b0;
        step();

        // Bypass: M-mode, and Sv39 disabled in satp
        mode = 2'd3;
        satp = SATP_SV39;
        local_lookup("byp_m", 64'h0000_0000_8000_1234, 64'h0000_0000_8000_1234);
        step();
        check("byp_pulse", 64'(resp_valid), 64'd0);
        check("byp_nowk",  64'(walk_req_valid), 64'd0);
        mode = 2'd0;
        satp = 64'h0;
        local_lookup("byp_bare", 64'hFFFF_FFC0_0000_0ABC, 64'hFFFF_FFC0_0000_0ABC);

        // Miss then hit
        satp = SATP_SV39;
        walk_txn("miss1", 64'h0000_0000_1234_5567, 27'h001_2345, 1'b0, 44'h0_0008_0042, 1'b0,
                 64'h0000_0000_8004_2567);
        local_lookup("hit1",  64'h0000_0000_1234_5567, 64'h0000_0000_8004_2567);
        local_lookup("hit1b", 64'h0000_0000_1234_5FFF, 64'h0000_0000_8004_2FFF);

        // Fault: no fill, so the same VPN misses again
        walk_txn("flt1", 64'h0000_0000_0ABC_D123, 27'h000_ABCD, 1'b0, 44'h0_0000_0777, 1'b1, 64'h0);
        walk_txn("flt2", 64'h0000_0000_0ABC_D123, 27'h000_ABCD, 1'b0, 44'h0_0000_0777, 1'b1, 64'h0);
        local_lookup("hit1c", 64'h0000_0000_1234_5004, 64'h0000_0000_8004_2004);

        // Replacement: nine VPNs into eight entries
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 9; i++) begin
            walk_txn("fill", (64'(i + 1) << 12) | 64'h0AB, 27'(i + 1), 1'b0,
                     44'(32'h100 + 32'(i)), 1'b0, (64'(32'h100 + 32'(i)) << 12) | 64'h0AB);
        end
        walk_txn("evict1", 64'h0000_0000_0000_10AB, 27'h000_0001, 1'b0, 44'h0_0000_0DEAD, 1'b1, 64'h0);
        local_lookup("keep2", 64'h0000_0000_0000_20AB, 64'h0000_0000_0010_10AB);
        local_lookup("keep8", 64'h0000_0000_0000_80AB, 64'h0000_0000_0010_70AB);
        local_lookup("keep9", 64'h0000_0000_0000_90AB, 64'h0000_0000_0010_80AB);

        // Flush during WALK_WAIT: response still delivered, not cached
        walk_txn("kill", 64'h0000_0000_0005_5123, 27'h000_0055, 1'b1, 44'h0_0000_5_5555, 1'b0,
                 64'h0000_0000_5555_5123);
        walk_txn("kill_re", 64'h0000_0000_0005_5123, 27'h000_0055, 1'b0, 44'h0, 1'b1, 64'h0);
        start_miss("kill_k2", 64'h0000_0000_0000_20AB, 27'h000_0002);
        finish_walk("kill_k2", 27'h000_0002, 1'b0, 44'h0, 1'b1, 64'h0);

        // Flush coincident with a lookup of a cached VPN
        walk_txn("f77", 64'h0000_0000_0007_7456, 27'h000_0077, 1'b0, 44'h0_0000_0777, 1'b0,
                 64'h0000_0000_0077_7456);
        local_lookup("hit77", 64'h0000_0000_0007_7456, 64'h0000_0000_0077_7456);
        flush = 1'b1;
        start_miss("race", 64'h0000_0000_0007_7456, 27'h000_0077);
        flush = 1'b0;
        finish_walk("race", 27'h000_0077, 1'b0, 44'h0, 1'b1, 64'h0);

        // Reset mid-walk
        walk_txn("f99", 64'h0000_0000_0009_9ABC, 27'h000_0099, 1'b0, 44'h0_0000_0999, 1'b0,
                 64'h0000_0000_0099_9ABC);
        local_lookup("hit99", 64'h0000_0000_0009_9ABC, 64'h0000_0000_0099_9ABC);
        start_miss("rmw", 64'h0000_0000_0003_3000, 27'h000_0033);
        walk_req_ready = 1'b1;
        step();
        walk_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        check("rmw_wreq",  64'(walk_req_valid), 64'd0);
        check("rmw_wvpn",  64'(walk_req_vpn), 64'd0);
        check("rmw_rv",    64'(resp_valid), 64'd0);
        check("rmw_ready", 64'(lookup_ready), 64'd1);
        step();
        reset = 1'b0;
        walk_resp_valid = 1'b1;
        walk_resp_ppn   = 44'h0_0000_0ABC;
        step();
        walk_resp_valid = 1'b0;
        check("stale_rv",  64'(resp_valid), 64'd0);
        check("stale_rdy", 64'(lookup_ready), 64'd1);
        walk_txn("post_rst", 64'h0000_0000_0009_9ABC, 27'h000_0099, 1'b0, 44'h0, 1'b1, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
